regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port register file; successor to the single-write 32x32 file in the CPU datapath.
//  Two write ports (pipeline writeback + load/return path) and two operand read ports.
//  Also provides a debug read port, optional write-to-read bypass, and a sequenced bulk-clear engine.
//  Sits between decode (reads) and writeback (writes); debug port feeds the board display/monitor.
// PARAMETERS
//  WIDTH     32  data width per register
//  DEPTH     32  number of registers (2..256, need not be a power of 2)
//  ZERO_REG  1   1: register 0 hardwired to zero (writes dropped, reads 0); 0: ordinary register
//  BYPASS    1   1: same-cycle write data forwarded to rd_1/rd_2; 0: no forwarding
//  AW        $clog2(DEPTH) derived address width (localparam, not overridable)
// PORTS
//  clock       in   1      rising-edge clock
//  reset       in   1      asynchronous, active-low reset
//  we_a        in   1      write enable, port A
//  wa_a        in   AW     write address, port A
//  wd_a        in   WIDTH  write data, port A
//  we_b        in   1      write enable, port B (priority port)
//  wa_b        in   AW     write address, port B
//  wd_b        in   WIDTH  write data, port B
//  ra_1/ra_2   in   AW     operand read addresses
//  rd_1/rd_2   out  WIDTH  operand read data (combinational)
//  ra_dbg      in   AW     debug read address
//  rd_dbg      out  WIDTH  debug read data (combinational, never bypassed)
//  clear_req   in   1      single-cycle pulse: start bulk clear
//  clear_busy  out  1      high while bulk clear in progress
// BEHAVIOUR
//  - reset low: all registers 0, FSM=IDLE, clear counter 0, clear_busy 0, immediately (async); release sync to clock.
//  - Write: at posedge, entry wa_x <= wd_x when we_x=1, address < DEPTH, not (ZERO_REG && addr==0), FSM=IDLE.
//  - Same-address dual write: port B wins; port A is dropped for that cycle.
//  - Read: rd = reg[ra]; returns 0 for ra >= DEPTH, or for ra==0 when ZERO_REG=1. Write visible next cycle.
//  - Bypass (BYPASS=1, FSM=IDLE): if a write qualifies this cycle at ra_1/ra_2, rd shows that wd now (B over A).
//  - Bypass never applies to rd_dbg.
//  - Clear FSM, states IDLE, CLEAR:
//    IDLE --clear_req--> CLEAR, cnt=0. In CLEAR: reg[cnt] <= 0, cnt++ each cycle.
//    On cnt==DEPTH-1: clear that entry and return to IDLE.
//  - clear_busy = (FSM==CLEAR): high exactly DEPTH cycles starting the cycle after clear_req.
//  - During CLEAR: all write enables are ignored (no store, no bypass); clear_req is ignored.
//    Reads return live contents: entries already cleared read 0, the rest keep their old values.
//  - reset low mid-clear: abort to IDLE; every entry is 0 anyway.
//  - Width rules: no arithmetic on data; cnt is AW+1 bits so DEPTH=2^AW terminates without wrap.
// STRUCTURE
//  - regfile_pkg: FSM state localparams (ST_IDLE, ST_CLEAR) and a clog2 function.
//  - Sub-module regfile_clear_seq: holds the FSM and counter.
//    Outputs clear_busy, clr_en and clr_addr; the storage array stays in regfile_mp.
// TESTING
//  1 reset low mid-run -> all rd_* = 0 and clear_busy = 0 without a clock edge; write 5<=0xDEADBEEF after release -> rd_1(5) = 0xDEADBEEF next cycle.
//  2 we_a=we_b=1, wa_a=wa_b=7, wd_a=0x1111, wd_b=0x2222 -> reg7 = 0x2222.
//    BYPASS=1: rd_1(ra=7) = 0x2222 in the same cycle; rd_dbg(7) still shows the old value until the edge.
//  3 ZERO_REG=1: write 0<=0xFFFFFFFF -> rd_1(0)=0. ZERO_REG=0: same write -> rd_1(0)=0xFFFFFFFF.
//  4 fill all 32 regs with index*3, pulse clear_req -> clear_busy high exactly 32 cycles.
//    Mid-sweep, reg[k] reads 0 for k<cnt and k*3 otherwise; all 0 at the end.
//    A write and a clear_req issued during the sweep have no effect.
//  5 DEPTH=20: write addr 25 -> no entry changes; rd_2(ra=25)=0; clear takes 20 cycles.
//  6 reset low at clear cycle 10 -> clear_busy=0 immediately, all 0; a new clear_req after release completes normally.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  // Ceiling log2, never less than 1 so a 2-entry file still gets a 1-bit address.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x * 2;
      r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Bulk-clear sequencer: walks entries 0..DEPTH-1, one per cycle, after a clear_req pulse.
// clear_busy is high for exactly DEPTH cycles; requests while busy are ignored.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear_req,
  output logic          clear_busy,
  output logic          clr_en,
  output logic [AW-1:0] clr_addr
);

  clr_state_t  state, state_nxt;
  logic [AW:0] cnt, cnt_nxt;
  logic        last;

  // cnt carries one spare bit so DEPTH == 2**AW reaches DEPTH-1 without wrapping.
  assign last = (int'(cnt) == DEPTH - 1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (clear_req) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        if (last) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
    endcase
  end

  assign clear_busy = (state == ST_CLEAR);
  assign clr_en     = clear_busy;
  assign clr_addr   = cnt[AW-1:0];

endmodule

// File: rtl/regfile_mp.sv
// Two-write / two-read register file with debug read, optional write bypass and bulk clear.
// Port B wins same-address writes; writes are frozen while a clear sweep is running.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 32,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we_a,
  input  logic [AW-1:0]    wa_a,
  input  logic [WIDTH-1:0] wd_a,
  input  logic             we_b,
  input  logic [AW-1:0]    wa_b,
  input  logic [WIDTH-1:0] wd_b,
  input  logic [AW-1:0]    ra_1,
  output logic [WIDTH-1:0] rd_1,
  input  logic [AW-1:0]    ra_2,
  output logic [WIDTH-1:0] rd_2,
  input  logic [AW-1:0]    ra_dbg,
  output logic [WIDTH-1:0] rd_dbg,
  input  logic             clear_req,
  output logic             clear_busy
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             clr_en;
  logic [AW-1:0]    clr_addr;
  logic             qa, qb, keep_a;

  regfile_clear_seq #(.DEPTH(DEPTH), .AW(AW)) u_clear_seq (
    .clock      (clock),
    .reset      (reset),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .clr_en     (clr_en),
    .clr_addr   (clr_addr)
  );

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  function automatic logic [WIDTH-1:0] entry(input logic [AW-1:0] a);
    return addr_ok(a) ? mem[a] : '0;
  endfunction

  assign qa     = we_a && !clear_busy && addr_ok(wa_a);
  assign qb     = we_b && !clear_busy && addr_ok(wa_b);
  assign keep_a = qa && !(qb && (wa_a == wa_b));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr_en) begin
      mem[clr_addr] <= '0;
    end else begin
      if (keep_a) mem[wa_a] <= wd_a;
      if (qb)     mem[wa_b] <= wd_b;
    end
  end

  always_comb begin
    rd_1 = entry(ra_1);
    rd_2 = entry(ra_2);
    if (BYPASS != 0) begin
      if (qb && (wa_b == ra_1))      rd_1 = wd_b;
      else if (qa && (wa_a == ra_1)) rd_1 = wd_a;
      if (qb && (wa_b == ra_2))      rd_2 = wd_b;
      else if (qa && (wa_a == ra_2)) rd_2 = wd_a;
    end
  end

  assign rd_dbg = entry(ra_dbg);

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: three instances (default, ZERO_REG=0/BYPASS=0, DEPTH=20) share one stimulus stream.
module tb_regfile_mp;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        we_a = 1'b0, we_b = 1'b0, clear_req = 1'b0;
  logic [4:0]  wa_a = '0, wa_b = '0, ra_1 = '0, ra_2 = '0, ra_dbg = '0;
  logic [31:0] wd_a = '0, wd_b = '0;

  logic [2:0][31:0] rd1, rd2, rdd;
  logic [2:0]       busy;

  int checks = 0;
  int errors = 0;
  int bcnt0, bcnt1, bcnt2;

  always #5 clock = ~clock;

  regfile_mp u0 (
    .clock(clock), .reset(reset),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .ra_1(ra_1), .rd_1(rd1[0]), .ra_2(ra_2), .rd_2(rd2[0]), .ra_dbg(ra_dbg), .rd_dbg(rdd[0]),
    .clear_req(clear_req), .clear_busy(busy[0])
  );

  regfile_mp #(.ZERO_REG(0), .BYPASS(0)) u1 (
    .clock(clock), .reset(reset),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .ra_1(ra_1), .rd_1(rd1[1]), .ra_2(ra_2), .rd_2(rd2[1]), .ra_dbg(ra_dbg), .rd_dbg(rdd[1]),
    .clear_req(clear_req), .clear_busy(busy[1])
  );

  regfile_mp #(.DEPTH(20)) u2 (
    .clock(clock), .reset(reset),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .ra_1(ra_1), .rd_1(rd1[2]), .ra_2(ra_2), .rd_2(rd2[2]), .ra_dbg(ra_dbg), .rd_dbg(rdd[2]),
    .clear_req(clear_req), .clear_busy(busy[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_rd1_u0", rd1[0], 32'h0);
    chk("rst_busy_u0", {31'b0, busy[0]}, 32'h0);
    tick();
    reset = 1'b1;

    // Write something, then pull reset mid-cycle: everything clears without an edge.
    tick();
    we_a = 1'b1; wa_a = 5'd5; wd_a = 32'h1234_5678; ra_1 = 5'd5;
    tick();
    we_a = 1'b0;
    #1;
    chk("pre_rst_rd1_u0", rd1[0], 32'h1234_5678);
    reset = 1'b0;
    #1;
    chk("async_rst_rd1_u0", rd1[0], 32'h0);
    chk("async_rst_rd1_u1", rd1[1], 32'h0);
    chk("async_rst_busy_u0", {31'b0, busy[0]}, 32'h0);
    tick();
    reset = 1'b1;

    // Write 5 <= DEADBEEF: bypass shows it now, non-bypass instance only after the edge.
    tick();
    we_a = 1'b1; wa_a = 5'd5; wd_a = 32'hDEAD_BEEF; ra_1 = 5'd5;
    #1;
    chk("byp_same_cycle_u0", rd1[0], 32'hDEAD_BEEF);
    chk("nobyp_same_cycle_u1", rd1[1], 32'h0);
    tick();
    we_a = 1'b0;
    #1;
    chk("wr5_u0", rd1[0], 32'hDEAD_BEEF);
    chk("wr5_u1", rd1[1], 32'hDEAD_BEEF);
    chk("wr5_u2", rd1[2], 32'hDEAD_BEEF);

    // Same-address dual write: port B wins.
    we_a = 1'b1; wa_a = 5'd7; wd_a = 32'h1111;
    we_b = 1'b1; wa_b = 5'd7; wd_b = 32'h2222;
    ra_1 = 5'd7; ra_dbg = 5'd7;
    #1;
    chk("dual_byp_u0", rd1[0], 32'h2222);
    chk("dual_dbg_old_u0", rdd[0], 32'h0);
    chk("dual_nobyp_u1", rd1[1], 32'h0);
    tick();
    we_a = 1'b0; we_b = 1'b0;
    #1;
    chk("dual_reg7_u0", rd1[0], 32'h2222);
    chk("dual_reg7_u1", rd1[1], 32'h2222);
    chk("dual_dbg_new_u0", rdd[0], 32'h2222);

    // Write to register 0: hardwired zero vs ordinary register.
    we_a = 1'b1; wa_a = 5'd0; wd_a = 32'hFFFF_FFFF; ra_1 = 5'd0;
    #1;
    chk("zero_nobyp_u0", rd1[0], 32'h0);
    tick();
    we_a = 1'b0;
    #1;
    chk("zero_reg_u0", rd1[0], 32'h0);
    chk("zero_reg_u1", rd1[1], 32'hFFFF_FFFF);

    // Fill all 32 addresses with index*3 (DEPTH=20 instance drops 20..31).
    for (int i = 0; i < 32; i++) begin
      we_a = 1'b1; wa_a = 5'(i); wd_a = 32'(i * 3);
      tick();
    end
    we_a = 1'b0;
    ra_1 = 5'd19; ra_2 = 5'd25; ra_dbg = 5'd31;
    #1;
    chk("fill_r19_u2", rd1[2], 32'd57);
    chk("oob_r25_u2", rd2[2], 32'h0);
    chk("fill_r25_u0", rd2[0], 32'd75);
    chk("fill_r31_dbg_u0", rdd[0], 32'd93);

    // Bulk clear sweep.
    clear_req = 1'b1;
    bcnt0 = 0; bcnt1 = 0; bcnt2 = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      clear_req = 1'b0;
      we_b = 1'b0;
      if (n == 10) begin
        clear_req = 1'b1;
        we_b = 1'b1; wa_b = 5'd12; wd_b = 32'hABCD;
        ra_1 = 5'd9; ra_2 = 5'd12; ra_dbg = 5'd11;
        #1;
        chk("mid_r9_cleared_u0", rd1[0], 32'h0);
        chk("mid_r12_nobyp_u0", rd2[0], 32'd36);
        chk("mid_r11_dbg_u0", rdd[0], 32'd33);
        chk("mid_r12_nobyp_u2", rd2[2], 32'd36);
      end
      if (n == 11) begin
        #1;
        chk("mid_r12_nowrite_u0", rd2[0], 32'd36);
        chk("mid_r11_u1", rdd[1], 32'd33);
      end
      if (busy[0]) bcnt0++;
      if (busy[1]) bcnt1++;
      if (busy[2]) bcnt2++;
    end
    chk("busy_cycles_u0", 32'(bcnt0), 32'd32);
    chk("busy_cycles_u1", 32'(bcnt1), 32'd32);
    chk("busy_cycles_u2", 32'(bcnt2), 32'd20);
    ra_1 = 5'd31; ra_2 = 5'd12; ra_dbg = 5'd7;
    #1;
    chk("post_clr_r31_u0", rd1[0], 32'h0);
    chk("post_clr_r12_u0", rd2[0], 32'h0);
    chk("post_clr_r7_u1", rdd[1], 32'h0);
    chk("post_clr_r12_u2", rd2[2], 32'h0);
    chk("post_clr_busy_u0", {31'b0, busy[0]}, 32'h0);

    // Reset in the middle of a sweep.
    tick();
    we_a = 1'b1; wa_a = 5'd20; wd_a = 32'h55;
    tick();
    we_a = 1'b0;
    clear_req = 1'b1;
    for (int n = 0; n <= 10; n++) begin
      tick();
      clear_req = 1'b0;
    end
    ra_1 = 5'd20;
    #1;
    chk("clr10_busy_u0", {31'b0, busy[0]}, 32'h1);
    chk("clr10_r20_u0", rd1[0], 32'h55);
    reset = 1'b0;
    #1;
    chk("clr_rst_busy_u0", {31'b0, busy[0]}, 32'h0);
    chk("clr_rst_r20_u0", rd1[0], 32'h0);
    tick();
    reset = 1'b1;
    tick();
    clear_req = 1'b1;
    bcnt0 = 0; bcnt2 = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      clear_req = 1'b0;
      if (busy[0]) bcnt0++;
      if (busy[2]) bcnt2++;
    end
    chk("reclear_cycles_u0", 32'(bcnt0), 32'd32);
    chk("reclear_cycles_u2", 32'(bcnt2), 32'd20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
